xbar_sched: RTL and testbench
=============================

XBAR_SCHED -- requirements
Module: xbar_sched

Interface
REQ-001 Parameters: N, default 8, number of MVUs/ports; W, default 64, data word width; BADDR, default 15, address width; CW, default 16, statistics counter width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 clr  input  1  reset; asynchronous, active-high.
REQ-004 en  input  1  scheduler enable; 0 means no grants are issued.
REQ-005 req_valid  input  N  per-source request valid.
REQ-006 req_to  input  N*N  per-source destination mask; bits [i*N +: N] belong to source i; multicast allowed.
REQ-007 req_addr  input  N*BADDR  per-source destination memory address.
REQ-008 req_word  input  N*W  per-source data word.
REQ-009 req_ready  output  N  per-source grant; combinational; a transfer occurs when req_valid[i] & req_ready[i].
REQ-010 dst_busy  input  N  per-destination back-pressure; destination j is not granted while dst_busy[j]=1.
REQ-011 send_to  output  N*N  registered crossbar selector bits, same layout as req_to.
REQ-012 send_en  output  N  registered per-source send enable.
REQ-013 send_addr  output  N*BADDR  registered per-source address.
REQ-014 send_word  output  N*W  registered per-source data.
REQ-015 stat_conflict  output  CW  saturating count of cycles with at least one valid, ungranted request while en=1.
REQ-016 err_nodest  output  1  sticky flag; set on a transfer with an all-zero destination mask.

Function
REQ-017 Purpose: no two granted sources SHALL share a destination bit in the same cycle, so the crossbar OR-reduction never merges words.
REQ-018 Arbitration: sources are scanned in order ptr, ptr+1, ..., ptr+N-1 (mod N); source i is granted iff en=1, req_valid[i]=1, req_to[i] has no bit overlapping destinations already claimed earlier in the scan, and no bit with dst_busy=1.
REQ-019 Multicast is atomic: a source is granted on all masked destinations or on none; partial grants are forbidden.
REQ-020 A source with valid=1 and req_to=0 is granted unconditionally (when en=1), claims no destination, and sets err_nodest.
REQ-021 Pointer: ptr resets to 0; after a cycle with at least one grant, ptr <= (first granted source in scan order + 1) mod N; otherwise ptr holds.
REQ-022 Latency: granted request appears on send_* exactly 1 cycle after the grant cycle; send_en[i] <= grant[i] & (req_to[i] != 0); send_to[i] <= req_to[i] if granted else 0.
REQ-023 Ungranted sources drive send_to/send_addr/send_word to 0 and send_en to 0 in the following cycle.
REQ-024 Requester rule: req_to/addr/word SHALL be held stable while valid=1 and ready=0; scheduler does not buffer ungranted requests.
REQ-025 Throughput: up to N disjoint transfers per cycle; a continuously requesting source is granted within N cycles when destinations are not busy (starvation-free).
REQ-026 stat_conflict increments by 1 per qualifying cycle and saturates at 2^CW-1.
REQ-027 en=0: req_ready=0, send_en=0 next cycle, ptr and stat_conflict hold.
REQ-028 N=1: req_ready = en & req_valid & ~(req_to & dst_busy); outputs registered as above.

Reset
REQ-029 While clr=1: send_to, send_en, send_addr, send_word, stat_conflict, err_nodest, ptr = 0; req_ready = 0.
REQ-030 clr asserted mid-transfer drops the in-flight registered transfer; no transfer is issued in the first cycle after clr deasserts unless a new grant occurs that cycle.

Verification
REQ-031 N=8, src0 and src3 valid, both to=0x04, ptr=0 -> src0 granted, src3 ready=0; next cycle send_en=0x01, send_to[0]=0x04; ptr=1; following cycle src3 granted.
REQ-032 src1 to=0x03, src2 to=0x02, src5 to=0x10, ptr=2 -> src2 and src5 granted, src1 not (overlap on bit1); stat_conflict +1.
REQ-033 All 8 sources valid to=0x01 for 8 cycles -> each source granted exactly once, order 0..7; stat_conflict=8.
REQ-034 src4 to=0x80, dst_busy=0x80 for 3 cycles then 0 -> no grant for 3 cycles, grant on cycle 4, send_to[4]=0x80 on cycle 5.
REQ-035 src6 valid, to=0x00 -> ready=1 same cycle, send_en[6]=0 next cycle, err_nodest=1 and stays 1 until clr.
REQ-036 clr pulsed one cycle after a grant -> send_en=0 immediately, stat_conflict=0, ptr=0, err_nodest=0.

Source files
------------

// File: rtl/xbar_sched.sv
// xbar_sched: rotating-priority crossbar scheduler that grants only destination-disjoint
// (optionally multicast) requests each cycle and registers the winners onto the send bus.
module xbar_sched #(
    parameter int N     = 8,
    parameter int W     = 64,
    parameter int BADDR = 15,
    parameter int CW    = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en_i,
    input  logic [N-1:0]       req_valid_i,
    input  logic [N*N-1:0]     req_to_i,
    input  logic [N*BADDR-1:0] req_addr_i,
    input  logic [N*W-1:0]     req_word_i,
    output logic [N-1:0]       req_ready_o,
    input  logic [N-1:0]       dst_busy_i,
    output logic [N*N-1:0]     send_to_o,
    output logic [N-1:0]       send_en_o,
    output logic [N*BADDR-1:0] send_addr_o,
    output logic [N*W-1:0]     send_word_o,
    output logic [CW-1:0]      stat_conflict_o,
    output logic               err_nodest_o
);
    localparam int PW = N > 1 ? $clog2(N) : 1;

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [N-1:0]       grant, claimed, nodest, send_en_q, send_en_d;
    logic [N*N-1:0]     send_to_q, send_to_d;
    logic [N*BADDR-1:0] send_addr_q, send_addr_d;
    logic [N*W-1:0]     send_word_q, send_word_d;
    logic [CW-1:0]      conf_q, conf_d;
    logic               err_q, err_d, found;
    int                 s;

    // Scan from ptr; a source wins only if its whole mask is free and not busy.
    always_comb begin
        grant   = '0;
        claimed = '0;
        found   = 1'b0;
        ptr_d   = ptr_q;
        s       = 0;
        for (int k = 0; k < N; k++) begin
            s = (int'(ptr_q) + k) % N;
            if (!clr && en_i && req_valid_i[s] && (req_to_i[s*N +: N] & (claimed | dst_busy_i)) == '0) begin
                grant[s] = 1'b1;
                claimed  = claimed | req_to_i[s*N +: N];
                if (!found) ptr_d = PW'((s + 1) % N);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        nodest      = '0;
        send_en_d   = '0;
        send_to_d   = '0;
        send_addr_d = '0;
        send_word_d = '0;
        for (int i = 0; i < N; i++) begin
            nodest[i]                   = grant[i] && req_to_i[i*N +: N] == '0;
            send_en_d[i]                = grant[i] && !nodest[i];
            send_to_d[i*N +: N]         = grant[i] ? req_to_i[i*N +: N] : '0;
            send_addr_d[i*BADDR +: BADDR] = grant[i] ? req_addr_i[i*BADDR +: BADDR] : '0;
            send_word_d[i*W +: W]       = grant[i] ? req_word_i[i*W +: W] : '0;
        end
        conf_d = (en_i && (req_valid_i & ~grant) != '0 && conf_q != '1) ? conf_q + 1'b1 : conf_q;
        err_d  = err_q | (nodest != '0);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr_q       <= '0;
            send_en_q   <= '0;
            send_to_q   <= '0;
            send_addr_q <= '0;
            send_word_q <= '0;
            conf_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            send_en_q   <= send_en_d;
            send_to_q   <= send_to_d;
            send_addr_q <= send_addr_d;
            send_word_q <= send_word_d;
            conf_q      <= conf_d;
            err_q       <= err_d;
        end
    end

    assign req_ready_o     = grant;
    assign send_en_o       = send_en_q;
    assign send_to_o       = send_to_q;
    assign send_addr_o     = send_addr_q;
    assign send_word_o     = send_word_q;
    assign stat_conflict_o = conf_q;
    assign err_nodest_o    = err_q;
endmodule

// File: tb/tb_xbar_sched.sv
// tb_xbar_sched: directed vector table plus hand sequences for reset, saturation and
// pointer behaviour of the crossbar scheduler (N=8, W=16, BADDR=8, CW=4).
module tb_xbar_sched;
    localparam int N = 8, W = 16, BADDR = 8, CW = 4;
    localparam logic [63:0] ALL01 = 64'h0101_0101_0101_0101;
    localparam logic [63:0] DIAG  = 64'h8040_2010_0804_0201;

    logic clk = 1'b0, clr = 1'b1, en = 1'b0;
    logic [N-1:0] valid = '0, busy = '0, ready, send_en;
    logic [N*N-1:0] to = '0, send_to;
    logic [N*BADDR-1:0] addr, send_addr;
    logic [N*W-1:0] word, send_word;
    logic [CW-1:0] conf;
    logic err;
    int ntest = 0, nfail = 0;

    typedef struct {
        logic        en;
        logic [7:0]  v;
        logic [63:0] to;
        logic [7:0]  busy;
        logic [7:0]  rdy;
        logic [7:0]  sen;
        logic [3:0]  conf;
        logic        err;
    } vec_t;
    vec_t tv [13];

    xbar_sched #(.N(N), .W(W), .BADDR(BADDR), .CW(CW)) dut (
        .clk(clk), .clr(clr), .en_i(en), .req_valid_i(valid), .req_to_i(to),
        .req_addr_i(addr), .req_word_i(word), .req_ready_o(ready), .dst_busy_i(busy),
        .send_to_o(send_to), .send_en_o(send_en), .send_addr_o(send_addr),
        .send_word_o(send_word), .stat_conflict_o(conf), .err_nodest_o(err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] t(int src, logic [7:0] m);
        return 64'(m) << (src * 8);
    endfunction

    task automatic chk(string n, logic [127:0] got, logic [127:0] exp);
        ntest++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic drive(logic e, logic [7:0] v, logic [63:0] m, logic [7:0] b);
        en = e; valid = v; to = m; busy = b;
    endtask

    // Inputs already driven after a negedge; checks ready, then the registered result.
    task automatic step(string tag, logic [7:0] rdy, logic [7:0] sen, logic [3:0] c, logic e);
        logic [63:0]  et;
        logic [63:0]  ea;
        logic [127:0] ew;
        et = '0; ea = '0; ew = '0;
        for (int i = 0; i < N; i++) if (rdy[i]) begin
            et[i*8 +: 8]  = to[i*8 +: 8];
            ea[i*8 +: 8]  = 8'h10 + 8'(i);
            ew[i*16 +: 16] = 16'hA000 + 16'(i);
        end
        #1 chk({tag, ".ready"}, 128'(ready), 128'(rdy));
        @(posedge clk); #1;
        chk({tag, ".send_en"}, 128'(send_en), 128'(sen));
        chk({tag, ".send_to"}, 128'(send_to), 128'(et));
        chk({tag, ".send_addr"}, 128'(send_addr), 128'(ea));
        chk({tag, ".send_word"}, send_word, ew);
        chk({tag, ".conflict"}, 128'(conf), 128'(c));
        chk({tag, ".err"}, 128'(err), 128'(e));
    endtask

    initial begin
        logic [7:0] oh;
        for (int i = 0; i < N; i++) begin
            addr[i*8 +: 8]  = 8'h10 + 8'(i);
            word[i*16 +: 16] = 16'hA000 + 16'(i);
        end
        tv[0]  = '{1'b1, 8'h09, t(0, 8'h04) | t(3, 8'h04), 8'h00, 8'h01, 8'h01, 4'd1, 1'b0};
        tv[1]  = '{1'b1, 8'h09, t(0, 8'h04) | t(3, 8'h04), 8'h00, 8'h08, 8'h08, 4'd2, 1'b0};
        tv[2]  = '{1'b1, 8'h02, t(1, 8'h01), 8'h00, 8'h02, 8'h02, 4'd2, 1'b0};
        tv[3]  = '{1'b1, 8'h26, t(1, 8'h03) | t(2, 8'h02) | t(5, 8'h10), 8'h00, 8'h24, 8'h24, 4'd3, 1'b0};
        tv[4]  = '{1'b1, 8'h10, t(4, 8'h80), 8'h80, 8'h00, 8'h00, 4'd4, 1'b0};
        tv[5]  = '{1'b1, 8'h10, t(4, 8'h80), 8'h80, 8'h00, 8'h00, 4'd5, 1'b0};
        tv[6]  = '{1'b1, 8'h10, t(4, 8'h80), 8'h80, 8'h00, 8'h00, 4'd6, 1'b0};
        tv[7]  = '{1'b1, 8'h10, t(4, 8'h80), 8'h00, 8'h10, 8'h10, 4'd6, 1'b0};
        tv[8]  = '{1'b1, 8'h40, 64'h0, 8'h00, 8'h40, 8'h00, 4'd6, 1'b1};
        tv[9]  = '{1'b0, 8'hFF, ALL01, 8'h00, 8'h00, 8'h00, 4'd6, 1'b1};
        tv[10] = '{1'b1, 8'hFF, ALL01, 8'h00, 8'h80, 8'h80, 4'd7, 1'b1};
        tv[11] = '{1'b1, 8'hFF, DIAG, 8'h00, 8'hFF, 8'hFF, 4'd7, 1'b1};
        tv[12] = '{1'b1, 8'h0E, t(1, 8'h0F) | t(2, 8'h30) | t(3, 8'h08), 8'h04, 8'h0C, 8'h0C, 4'd8, 1'b1};

        drive(1'b1, 8'hFF, ALL01, 8'h00);
        #1;
        chk("rst.ready", 128'(ready), 128'h0);
        chk("rst.send_en", 128'(send_en), 128'h0);
        chk("rst.conflict", 128'(conf), 128'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold.send_en", 128'(send_en), 128'h0);
        chk("rst_hold.err", 128'(err), 128'h0);
        @(negedge clk);
        drive(1'b0, 8'h00, 64'h0, 8'h00);
        clr = 1'b0;

        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            drive(tv[k].en, tv[k].v, tv[k].to, tv[k].busy);
            step($sformatf("vec%0d", k), tv[k].rdy, tv[k].sen, tv[k].conf, tv[k].err);
        end

        // Continuous all-to-one contention: strict rotation and counter saturation.
        @(negedge clk);
        drive(1'b0, 8'h00, 64'h0, 8'h00);
        clr = 1'b1;
        #1;
        chk("clrA.conflict", 128'(conf), 128'h0);
        chk("clrA.err", 128'(err), 128'h0);
        @(negedge clk);
        clr = 1'b0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            drive(1'b1, 8'hFF, ALL01, 8'h00);
            oh = 8'h01 << (c % 8);
            step($sformatf("rr%0d", c), oh, oh, (c + 1 > 15) ? 4'd15 : 4'(c + 1), 1'b0);
        end

        // Grant in flight, then an asynchronous clear wipes it and the pointer.
        @(negedge clk);
        drive(1'b1, 8'h44, t(2, 8'h01), 8'h00);
        step("pre_clr", 8'h44, 8'h04, 4'd15, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 64'h0, 8'h00);
        clr = 1'b1;
        #1;
        chk("clrB.send_en", 128'(send_en), 128'h0);
        chk("clrB.send_to", 128'(send_to), 128'h0);
        chk("clrB.conflict", 128'(conf), 128'h0);
        chk("clrB.err", 128'(err), 128'h0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
        chk("post_clr_idle.send_en", 128'(send_en), 128'h0);
        @(negedge clk);
        drive(1'b1, 8'hFF, ALL01, 8'h00);
        step("post_clr_ptr0", 8'h01, 8'h01, 4'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
